// File: rtl/i2s_rx.sv
// I2S receiver: synchronised serial inputs, slot framing FSM, stereo pair output.
// Optional macro I2S_RX_MONO_EN adds o_data_mono, the arithmetic average of L and R.
module i2s_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sclk,
  input  logic                  i_lrck,
  input  logic                  i_sdata,
  output logic [DATA_WIDTH-1:0] o_data_l,
  output logic [DATA_WIDTH-1:0] o_data_r,
  output logic                  o_valid,
`ifdef I2S_RX_MONO_EN
  output logic [DATA_WIDTH-1:0] o_data_mono,
`endif
  output logic                  o_frame_err
);

  // state | meaning
  // IDLE  | no slot framed; waiting for an lrck transition
  // SHIFT | capturing data bits of the current slot, MSB first
  // PAD   | word captured; ignoring remaining bits until lrck changes

  localparam int BW  = $clog2(DATA_WIDTH + 1);
  localparam int SCW = $clog2(2 * SLOT_WIDTH);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [SCW-1:0] SLOT_LOAD = SCW'(2 * SLOT_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  state_t                state, state_nxt;
  logic                  sclk_s1, sclk_s2, sclk_d;
  logic                  lrck_s1, lrck_s2, lrck_prev;
  logic                  sdata_s1, sdata_s2;
  logic                  sclk_rise, lrck_chg, slot_tc;
  logic [BW-1:0]         bit_cnt;
  logic [SCW-1:0]        slot_cnt;
  logic                  chan;
  logic [DATA_WIDTH-2:0] shift_reg;
  logic [DATA_WIDTH-1:0] word, left_hold;
  logic                  left_have;
  logic                  shift_en, cap_word, start_slot, err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_d   <= 1'b0;
      lrck_s1  <= 1'b0;
      lrck_s2  <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      sclk_s1  <= i_sclk;
      sclk_s2  <= sclk_s1;
      sclk_d   <= sclk_s2;
      lrck_s1  <= i_lrck;
      lrck_s2  <= lrck_s1;
      sdata_s1 <= i_sdata;
      sdata_s2 <= sdata_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign lrck_chg  = sclk_rise & (lrck_s2 != lrck_prev);
  assign slot_tc   = (slot_cnt == '0);
  assign word      = {shift_reg, sdata_s2};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    cap_word   = 1'b0;
    start_slot = 1'b0;
    err        = 1'b0;
    if (sclk_rise) begin
      case (state)
        IDLE: begin
          if (lrck_chg) begin
            state_nxt  = SHIFT;
            start_slot = 1'b1;
          end
        end
        SHIFT: begin
          // A change coinciding with the last data bit completes the word first.
          if (lrck_chg) begin
            state_nxt  = SHIFT;
            start_slot = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              shift_en = 1'b1;
              cap_word = 1'b1;
            end else begin
              err = 1'b1;
            end
          end else if (slot_tc) begin
            state_nxt = IDLE;
            err       = 1'b1;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              cap_word  = 1'b1;
              state_nxt = PAD;
            end
          end
        end
        PAD: begin
          if (lrck_chg) begin
            state_nxt  = SHIFT;
            start_slot = 1'b1;
          end else if (slot_tc) begin
            state_nxt = IDLE;
            err       = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef I2S_RX_MONO_EN
  logic [DATA_WIDTH:0]   mono_sum;
  logic [DATA_WIDTH-1:0] mono_avg;
  assign mono_sum = {left_hold[DATA_WIDTH-1], left_hold} + {word[DATA_WIDTH-1], word};
  assign mono_avg = DATA_WIDTH'(mono_sum >> 1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lrck_prev   <= 1'b0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      chan        <= 1'b0;
      shift_reg   <= '0;
      left_hold   <= '0;
      left_have   <= 1'b0;
      o_data_l    <= '0;
      o_data_r    <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef I2S_RX_MONO_EN
      o_data_mono <= '0;
`endif
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= err;
      if (sclk_rise) lrck_prev <= lrck_s2;
      if (shift_en) begin
        shift_reg <= word[DATA_WIDTH-2:0];
        bit_cnt   <= bit_cnt + BW'(1);
      end
      // slot timeout is a down-counter reloaded on every lrck transition
      if (start_slot) begin
        bit_cnt  <= '0;
        slot_cnt <= SLOT_LOAD;
        chan     <= lrck_s2;
      end else if (sclk_rise && !slot_tc) begin
        slot_cnt <= slot_cnt - SCW'(1);
      end
      if (err) left_have <= 1'b0;
      if (cap_word) begin
        if (!chan) begin
          left_hold <= word;
          left_have <= 1'b1;
        end else if (left_have) begin
          o_data_l  <= left_hold;
          o_data_r  <= word;
          o_valid   <= 1'b1;
          left_have <= 1'b0;
`ifdef I2S_RX_MONO_EN
          o_data_mono <= mono_avg;
`endif
        end
      end
    end
  end

endmodule
